audio_boxcar_filter: RTL and testbench

- Parametrised multichannel moving-average (boxcar) filter for the I2S audio path.
- Sits between the deserializer and the serializer. Accepts one frame (all channels) per sample strobe.
- Outputs the mean of the last DEPTH samples per channel, or the raw input in bypass mode.
- Replaces the fixed, wrap-prone cascaded running sum: bounded gain, signed arithmetic, clear/flush, status flags.

---
 rtl/audio_boxcar_filter.sv | 139 +++++++++++++
 tb/tb_audio_boxcar_filter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_boxcar_filter.sv
// Multichannel moving-average (boxcar) filter: one frame per strobe, channels
// processed serially, mean of the last 2**LOG2_DEPTH samples or raw bypass.
module audio_boxcar_filter #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 3,
    parameter int NUM_CH     = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    IN_VALID,
    input  logic [WIDTH*NUM_CH-1:0] AUD_IN,
    input  logic                    BYPASS,
    input  logic                    CLR,
    output logic [WIDTH*NUM_CH-1:0] AUD_OUT,
    output logic                    OUT_VALID,
    output logic                    BUSY,
    output logic                    WINDOW_FULL,
    output logic                    OVERRUN
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int ACC_W = WIDTH + LOG2_DEPTH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [CH_W-1:0]     CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, PROC, EMIT} state_t;
    state_t state, state_nxt;

    logic [CH_W-1:0]         ch;
    logic                    byp_lat;
    logic                    clr_pend;
    logic [LOG2_DEPTH-1:0]   wptr;
    logic [LOG2_DEPTH:0]     fill;
    logic signed [ACC_W-1:0] acc   [NUM_CH];
    logic signed [WIDTH-1:0] samp  [NUM_CH];
    logic signed [WIDTH-1:0] res   [NUM_CH];
    logic signed [WIDTH-1:0] dline [NUM_CH][DEPTH];

    logic signed [WIDTH-1:0] x_cur, old_cur, res_cur;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    last_ch;

    // Arithmetic shift floors toward minus infinity; the window sum always fits.
    function automatic logic signed [WIDTH-1:0] window_mean(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] shifted;
        shifted = sum >>> LOG2_DEPTH;
        return shifted[WIDTH-1:0];
    endfunction

    always_comb begin
        x_cur   = samp[ch];
        old_cur = (fill < FILL_MAX) ? '0 : dline[ch][wptr];
        acc_nxt = acc[ch] + ACC_W'(x_cur) - ACC_W'(old_cur);
        res_cur = byp_lat ? x_cur : window_mean(acc_nxt);
        last_ch = (ch == CH_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_VALID && !CLR) state_nxt = PROC;
            PROC:    if (last_ch) state_nxt = EMIT;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ch        <= '0;
            byp_lat   <= 1'b0;
            clr_pend  <= 1'b0;
            wptr      <= '0;
            fill      <= '0;
            OVERRUN   <= 1'b0;
            OUT_VALID <= 1'b0;
            AUD_OUT   <= '0;
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else begin
            OUT_VALID <= 1'b0;
            if (IN_VALID && state != IDLE) OVERRUN <= 1'b1;
            case (state)
                IDLE: begin
                    if (CLR) begin
                        wptr <= '0;
                        fill <= '0;
                        for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
                    end else if (IN_VALID) begin
                        ch      <= '0;
                        byp_lat <= BYPASS;
                    end
                end
                PROC: begin
                    acc[ch] <= acc_nxt;
                    if (CLR) clr_pend <= 1'b1;
                    if (last_ch) begin
                        ch        <= '0;
                        OUT_VALID <= 1'b1;
                        for (int c = 0; c < NUM_CH; c++)
                            AUD_OUT[c*WIDTH +: WIDTH] <= (CH_W'(c) == ch) ? res_cur : res[c];
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                EMIT: begin
                    // A clear requested mid-frame lands here, after the frame's own result.
                    if (clr_pend || CLR) begin
                        clr_pend <= 1'b0;
                        wptr     <= '0;
                        fill     <= '0;
                        for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
                    end else begin
                        wptr <= wptr + 1'b1;
                        if (fill != FILL_MAX) fill <= fill + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE && IN_VALID)
            for (int c = 0; c < NUM_CH; c++) samp[c] <= AUD_IN[c*WIDTH +: WIDTH];
        if (state == PROC) begin
            dline[ch][wptr] <= x_cur;
            res[ch]         <= res_cur;
        end
    end

    assign BUSY        = (state != IDLE);
    assign WINDOW_FULL = (fill == FILL_MAX);

endmodule

// File: tb/tb_audio_boxcar_filter.sv
// Directed scoreboard bench for audio_boxcar_filter (WIDTH=16, DEPTH=4, 2 channels).
module tb_audio_boxcar_filter;
    localparam int WIDTH      = 16;
    localparam int LOG2_DEPTH = 2;
    localparam int NUM_CH     = 2;

    logic        CLK = 1'b0;
    logic        RST_N, IN_VALID, BYPASS, CLR;
    logic [31:0] AUD_IN, AUD_OUT;
    logic        OUT_VALID, BUSY, WINDOW_FULL, OVERRUN;

    int checks = 0, errors = 0, ov_count = 0, cyc = 0, sent_cyc = 0, base = 0;
    logic [31:0] exp_q[$];
    int hist[NUM_CH][4];
    int fillm = 0;

    audio_boxcar_filter #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH), .NUM_CH(NUM_CH)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .AUD_IN(AUD_IN),
        .BYPASS(BYPASS), .CLR(CLR), .AUD_OUT(AUD_OUT), .OUT_VALID(OUT_VALID),
        .BUSY(BUSY), .WINDOW_FULL(WINDOW_FULL), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (OUT_VALID === 1'b1) ov_count <= ov_count + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        fillm = 0;
    endtask

    // Reference: straight sum over the stored window, divided by flooring shift.
    task automatic send_frame(input logic [15:0] c0, input logic [15:0] c1,
                              input logic byp, input int hold);
        logic [31:0] e;
        logic [15:0] smp[2];
        int s;
        smp[0] = c0;
        smp[1] = c1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = int'($signed(smp[c]));
            s = 0;
            for (int k = 0; k < 4 && k <= fillm; k++) s += hist[c][k];
            s = s >>> 2;
            e[c*16 +: 16] = byp ? smp[c] : s[15:0];
        end
        if (fillm < 4) fillm++;
        exp_q.push_back(e);
        @(posedge CLK); #1;
        IN_VALID = 1'b1;
        AUD_IN   = {c1, c0};
        BYPASS   = byp;
        @(posedge CLK); #1;
        sent_cyc = cyc;
        for (int h = 1; h < hold; h++) begin
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
    endtask

    task automatic expect_out(input string tag);
        int n;
        logic [31:0] e;
        n = 0;
        while (OUT_VALID !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_seen"}, 32'(n < 20), 32'd1);
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        // The edge that samples IN_VALID opens cycle t+1; OUT_VALID sits NUM_CH edges later.
        check({tag, "_lat"}, 32'(cyc - sent_cyc), 32'(NUM_CH));
        check({tag, "_data"}, AUD_OUT, e);
    endtask

    task automatic finish_frame(input string tag);
        expect_out(tag);
        @(negedge CLK);
        check({tag, "_wfull"}, 32'(WINDOW_FULL), 32'(fillm == 4));
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    task automatic clear_idle();
        @(posedge CLK); #1;
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        model_clear();
        @(negedge CLK);
        check("clr_wfull", 32'(WINDOW_FULL), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_aud"}, AUD_OUT, 32'd0);
        check({tag, "_ov"}, 32'(OUT_VALID), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_wfull"}, 32'(WINDOW_FULL), 32'd0);
        check({tag, "_ovr"}, 32'(OVERRUN), 32'd0);
    endtask

    initial begin
        RST_N = 1'b0; IN_VALID = 1'b0; BYPASS = 1'b0; CLR = 1'b0; AUD_IN = '0;

        // Reset with random activity on the inputs
        repeat (5) begin
            @(posedge CLK); #1;
            IN_VALID = 1'($urandom_range(0, 1));
            BYPASS   = 1'($urandom_range(0, 1));
            CLR      = 1'($urandom_range(0, 1));
            AUD_IN   = $urandom;
        end
        @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK); #1;
        IN_VALID = 1'b0; BYPASS = 1'b0; CLR = 1'b0; AUD_IN = '0;
        RST_N = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        check("no_spurious_ov", 32'(ov_count), 32'd0);

        // Step response and steady state
        for (int i = 0; i < 5; i++) begin
            send_frame(16'h0100, 16'hFFFC, 1'b0, 1);
            finish_frame($sformatf("step%0d", i));
            repeat (3) @(posedge CLK);
        end
        check("step_final", AUD_OUT, 32'hFFFC_0100);

        // Full scale and window slide
        clear_idle();
        for (int i = 0; i < 8; i++) begin
            send_frame((i < 4) ? 16'h7FFF : 16'h8000, (i < 4) ? 16'h8000 : 16'h7FFF, 1'b0, 1);
            finish_frame($sformatf("fs%0d", i));
        end
        check("fs_final", AUD_OUT, 32'h7FFF_8000);

        // Bypass keeps history updated
        clear_idle();
        for (int i = 0; i < 4; i++) begin
            send_frame(16'h0100, 16'h0200, 1'b0, 1);
            finish_frame($sformatf("pre%0d", i));
        end
        send_frame(16'h1234, 16'h0200, 1'b1, 1);
        finish_frame("byp_on");
        check("byp_raw", 32'(AUD_OUT[15:0]), 32'h0000_1234);
        send_frame(16'h0000, 16'h0000, 1'b0, 1);
        finish_frame("byp_off");
        check("byp_hist", 32'(AUD_OUT[15:0]), 32'h0000_050D);

        // CLR and IN_VALID together in IDLE: frame dropped, no overrun
        base = ov_count;
        @(posedge CLK); #1;
        CLR = 1'b1; IN_VALID = 1'b1; AUD_IN = 32'h1111_2222;
        @(posedge CLK); #1;
        CLR = 1'b0; IN_VALID = 1'b0;
        model_clear();
        repeat (6) @(posedge CLK);
        #1;
        check("clrin_drop", 32'(ov_count - base), 32'd0);
        check("clrin_ovr", 32'(OVERRUN), 32'd0);
        check("clrin_wfull", 32'(WINDOW_FULL), 32'd0);

        // Overrun: second strobe while busy is dropped
        base = ov_count;
        send_frame(16'h0100, 16'h0100, 1'b0, 2);
        finish_frame("ovr");
        repeat (6) @(posedge CLK);
        #1;
        check("ovr_count", 32'(ov_count - base), 32'd1);
        check("ovr_flag", 32'(OVERRUN), 32'd1);

        // CLR during PROC: frame completes, clear applied afterwards
        send_frame(16'h0300, 16'h0300, 1'b0, 1);
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        expect_out("clrp");
        model_clear();
        @(negedge CLK);
        check("clrp_wfull", 32'(WINDOW_FULL), 32'd0);
        repeat (3) @(posedge CLK);
        send_frame(16'h0100, 16'h0100, 1'b0, 1);
        finish_frame("post_clr");
        check("post_clr_val", AUD_OUT, 32'h0040_0040);
        check("ovr_sticky", 32'(OVERRUN), 32'd1);

        // Reset mid-frame
        repeat (3) @(posedge CLK);
        base = ov_count;
        send_frame(16'h0100, 16'h0100, 1'b0, 1);
        RST_N = 1'b0;
        exp_q.delete();
        model_clear();
        @(negedge CLK);
        check_all_zero("midrst");
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("midrst_no_ov", 32'(ov_count - base), 32'd0);
        send_frame(16'h0100, 16'h0100, 1'b0, 1);
        finish_frame("post_rst");
        check("post_rst_val", AUD_OUT, 32'h0040_0040);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
